// File: rtl/norz_phase_sequencer.sv
// -----------------------------------------------------------------------------
// norz_phase_sequencer
//
// Front end of the instruction decoder tree. Owns the phase counter (XPT), the
// opcode register (ITABLE), the one-hot machine-cycle mode register
// (CM1/CMR/CMA) and the multi-byte continuation flags (F_HL/F_A/F_JP).
//
// The opcode is captured from DataIn during the M1 fetch phase. True and
// complemented copies of XPT and ITABLE go to the decoder. The decoder's
// PR_/P2_ strobes come back and take effect at the next rising clock edge.
//
// Ports
//   clk                 system clock, all state changes on the rising edge
//   reset               synchronous active-high reset, overrides everything
//   stall               memory wait: freezes all state, masks all strobes
//   DataIn[7:0]         opcode/data bus, sampled on the fetch phase
//   PR_Reset_XPT        XPT returns to 0 at the next edge
//   P2_Reset_ITABLE     clear ITABLE, valid and the continuation flags
//   P2_Set_CM1/CMR/CMA  select the next machine-cycle mode
//   P2_Set_ILDlnnlHL_1  set F_HL
//   P2_Set_ILDAlnnl_1   set F_A
//   P2_Set_IJPnn_1      set F_JP
//   XPT/notXPT[3:0]     phase counter and its complement
//   ITABLE/notITABLE    opcode register and its complement
//   decode_enable       decoder root enable (valid opcode, not stalled)
//   CM1/CMR/CMA         one-hot machine-cycle mode
//   F_HL/F_A/F_JP       continuation flags
//   phase_overflow      sticky: XPT wrapped from 15 to 0
//   mode_conflict       sticky: two or more mode strobes in one cycle
// -----------------------------------------------------------------------------
module norz_phase_sequencer #(
  parameter int unsigned FETCH_PHASE = 1,
  parameter int unsigned XPT_W       = 4   // fixed at 4, other widths unsupported
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [7:0]       DataIn,
  input  logic             PR_Reset_XPT,
  input  logic             P2_Reset_ITABLE,
  input  logic             P2_Set_CM1,
  input  logic             P2_Set_CMR,
  input  logic             P2_Set_CMA,
  input  logic             P2_Set_ILDlnnlHL_1,
  input  logic             P2_Set_ILDAlnnl_1,
  input  logic             P2_Set_IJPnn_1,
  output logic [XPT_W-1:0] XPT,
  output logic [XPT_W-1:0] notXPT,
  output logic [7:0]       ITABLE,
  output logic [7:0]       notITABLE,
  output logic             decode_enable,
  output logic             CM1,
  output logic             CMR,
  output logic             CMA,
  output logic             F_HL,
  output logic             F_A,
  output logic             F_JP,
  output logic             phase_overflow,
  output logic             mode_conflict
);

  // One-hot machine-cycle modes. Bit 0 is M1 so the reset state is 3'b001.
  localparam logic [2:0] MODE_M1 = 3'b001;
  localparam logic [2:0] MODE_MR = 3'b010;
  localparam logic [2:0] MODE_MA = 3'b100;

  localparam logic [XPT_W-1:0] FetchPhaseL = FETCH_PHASE[XPT_W-1:0];
  localparam logic [XPT_W-1:0] XptMax      = {XPT_W{1'b1}};

  logic [XPT_W-1:0] r_xpt;
  logic [7:0]       r_itable;
  logic             r_valid;
  logic [2:0]       r_mode;
  logic             r_fHl;
  logic             r_fA;
  logic             r_fJp;
  logic             r_phaseOverflow;
  logic             r_modeConflict;

  logic [XPT_W-1:0] w_xptNext;
  logic [7:0]       w_itableNext;
  logic             w_validNext;
  logic [2:0]       w_modeNext;
  logic             w_fHlNext;
  logic             w_fANext;
  logic             w_fJpNext;
  logic             w_phaseOverflowNext;
  logic             w_modeConflictNext;

  logic             w_fetch;
  logic [1:0]       w_modeStrobeCount;

  // A fetch happens only in M1 at the fetch phase. The ITABLE clear strobe
  // takes priority, so it blocks the load in the same cycle.
  assign w_fetch = r_mode[0] && (r_xpt == FetchPhaseL) && !P2_Reset_ITABLE;

  assign w_modeStrobeCount = 2'(P2_Set_CM1) + 2'(P2_Set_CMR) + 2'(P2_Set_CMA);

  // Phase counter. PR_Reset_XPT wins over the wrap. A natural wrap from the
  // top value is a sequencing error and latches the sticky overflow flag.
  always_comb begin
    w_xptNext           = r_xpt;
    w_phaseOverflowNext = r_phaseOverflow;
    if (!stall) begin
      if (PR_Reset_XPT) begin
        w_xptNext = '0;
      end else if (r_xpt == XptMax) begin
        w_xptNext           = '0;
        w_phaseOverflowNext = 1'b1;
      end else begin
        w_xptNext = r_xpt + 1'b1;
      end
    end
  end

  // Opcode register and valid bit. A clear beats a fetch in the same cycle.
  always_comb begin
    w_itableNext = r_itable;
    w_validNext  = r_valid;
    if (!stall) begin
      if (P2_Reset_ITABLE) begin
        w_itableNext = 8'h00;
        w_validNext  = 1'b0;
      end else if (w_fetch) begin
        w_itableNext = DataIn;
        w_validNext  = 1'b1;
      end
    end
  end

  // Continuation flags. The ITABLE clear removes them, but a set strobe in the
  // same cycle wins, so a new multi-byte sequence can start on the edge that
  // retires the old opcode.
  always_comb begin
    w_fHlNext = r_fHl;
    w_fANext  = r_fA;
    w_fJpNext = r_fJp;
    if (!stall) begin
      if (P2_Reset_ITABLE) begin
        w_fHlNext = 1'b0;
        w_fANext  = 1'b0;
        w_fJpNext = 1'b0;
      end
      if (P2_Set_ILDlnnlHL_1) w_fHlNext = 1'b1;
      if (P2_Set_ILDAlnnl_1)  w_fANext  = 1'b1;
      if (P2_Set_IJPnn_1)     w_fJpNext = 1'b1;
    end
  end

  // Mode register. Simultaneous strobes resolve CM1 > CMR > CMA, which keeps
  // the mode one-hot. They also latch the sticky conflict flag.
  always_comb begin
    w_modeNext         = r_mode;
    w_modeConflictNext = r_modeConflict;
    if (!stall) begin
      if (P2_Set_CM1) begin
        w_modeNext = MODE_M1;
      end else if (P2_Set_CMR) begin
        w_modeNext = MODE_MR;
      end else if (P2_Set_CMA) begin
        w_modeNext = MODE_MA;
      end
      if (w_modeStrobeCount > 2'd1) begin
        w_modeConflictNext = 1'b1;
      end
    end
  end

  // State registers. Reset is synchronous and overrides any strobe in that
  // cycle, so a reset in the middle of an instruction leaves no partial update.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_xpt           <= '0;
      r_itable        <= 8'h00;
      r_valid         <= 1'b0;
      r_mode          <= MODE_M1;
      r_fHl           <= 1'b0;
      r_fA            <= 1'b0;
      r_fJp           <= 1'b0;
      r_phaseOverflow <= 1'b0;
      r_modeConflict  <= 1'b0;
    end else begin
      r_xpt           <= w_xptNext;
      r_itable        <= w_itableNext;
      r_valid         <= w_validNext;
      r_mode          <= w_modeNext;
      r_fHl           <= w_fHlNext;
      r_fA            <= w_fANext;
      r_fJp           <= w_fJpNext;
      r_phaseOverflow <= w_phaseOverflowNext;
      r_modeConflict  <= w_modeConflictNext;
    end
  end

  assign XPT            = r_xpt;
  assign notXPT         = ~r_xpt;
  assign ITABLE         = r_itable;
  assign notITABLE      = ~r_itable;
  assign CM1            = r_mode[0];
  assign CMR            = r_mode[1];
  assign CMA            = r_mode[2];
  assign F_HL           = r_fHl;
  assign F_A            = r_fA;
  assign F_JP           = r_fJp;
  assign phase_overflow = r_phaseOverflow;
  assign mode_conflict  = r_modeConflict;

  // The decoder is enabled only while a valid opcode is held. Stall and reset
  // gate the enable combinationally so that the decoder sees them immediately.
  assign decode_enable  = r_valid & ~stall & ~reset;

endmodule

// File: tb/tb_norz_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_norz_phase_sequencer
//
// Scoreboard bench for norz_phase_sequencer. The stimulus process drives
// inputs on the falling edge. It advances a behavioural model of the sequencer
// and pushes the outputs it expects after the next rising edge. A separate
// monitor samples the DUT shortly after each rising edge. It pops one expected
// record and compares every output field against that record.
// -----------------------------------------------------------------------------
module tb_norz_phase_sequencer;

  localparam int FetchPhase = 1;

  logic       clk = 1'b0;
  logic       reset;
  logic       stall;
  logic [7:0] DataIn;
  logic       PR_Reset_XPT, P2_Reset_ITABLE;
  logic       P2_Set_CM1, P2_Set_CMR, P2_Set_CMA;
  logic       P2_Set_ILDlnnlHL_1, P2_Set_ILDAlnnl_1, P2_Set_IJPnn_1;
  logic [3:0] XPT, notXPT;
  logic [7:0] ITABLE, notITABLE;
  logic       decode_enable, CM1, CMR, CMA, F_HL, F_A, F_JP;
  logic       phase_overflow, mode_conflict;

  norz_phase_sequencer #(.FETCH_PHASE(FetchPhase), .XPT_W(4)) dut (
    .clk(clk), .reset(reset), .stall(stall), .DataIn(DataIn),
    .PR_Reset_XPT(PR_Reset_XPT), .P2_Reset_ITABLE(P2_Reset_ITABLE),
    .P2_Set_CM1(P2_Set_CM1), .P2_Set_CMR(P2_Set_CMR), .P2_Set_CMA(P2_Set_CMA),
    .P2_Set_ILDlnnlHL_1(P2_Set_ILDlnnlHL_1), .P2_Set_ILDAlnnl_1(P2_Set_ILDAlnnl_1),
    .P2_Set_IJPnn_1(P2_Set_IJPnn_1),
    .XPT(XPT), .notXPT(notXPT), .ITABLE(ITABLE), .notITABLE(notITABLE),
    .decode_enable(decode_enable), .CM1(CM1), .CMR(CMR), .CMA(CMA),
    .F_HL(F_HL), .F_A(F_A), .F_JP(F_JP),
    .phase_overflow(phase_overflow), .mode_conflict(mode_conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         xpt;
    int         itable;
    int         mode;      // 0 = M1, 1 = memory read, 2 = A-access
    bit         fHl, fA, fJp;
    bit         overflow, conflict, decEn;
  } expect_t;

  expect_t sbQueue[$];

  int testsRun  = 0;
  int failCount = 0;
  int cycleNum  = 0;

  // Model state: plain integers describing what the sequencer should hold.
  int mXpt, mItable, mMode;
  bit mValid, mHl, mA, mJp, mOvf, mConflict;

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycleNum, act, exp);
    end
  endtask

  // Drive one cycle of inputs, step the model over the coming edge, and queue
  // the outputs expected after that edge.
  task automatic applyStimulus(input bit rst, input bit st, input logic [7:0] data,
                               input bit prx, input bit prIt,
                               input bit cm1, input bit cmr, input bit cma,
                               input bit fhl, input bit fa, input bit fjp);
    expect_t e;
    bit      fetchNow;
    int      nStrobes;
    @(negedge clk);
    reset = rst; stall = st; DataIn = data;
    PR_Reset_XPT = prx; P2_Reset_ITABLE = prIt;
    P2_Set_CM1 = cm1; P2_Set_CMR = cmr; P2_Set_CMA = cma;
    P2_Set_ILDlnnlHL_1 = fhl; P2_Set_ILDAlnnl_1 = fa; P2_Set_IJPnn_1 = fjp;

    if (rst) begin
      mXpt = 0; mItable = 0; mValid = 0; mMode = 0;
      mHl = 0; mA = 0; mJp = 0; mOvf = 0; mConflict = 0;
    end else if (!st) begin
      fetchNow = (mMode == 0) && (mXpt == FetchPhase);
      if (prx) mXpt = 0;
      else if (mXpt == 15) begin mXpt = 0; mOvf = 1; end
      else mXpt = mXpt + 1;
      if (prIt) begin
        mItable = 0; mValid = 0; mHl = 0; mA = 0; mJp = 0;
      end else if (fetchNow) begin
        mItable = data; mValid = 1;
      end
      if (fhl) mHl = 1;
      if (fa)  mA  = 1;
      if (fjp) mJp = 1;
      nStrobes = int'(cm1) + int'(cmr) + int'(cma);
      if (nStrobes > 1) mConflict = 1;
      if (cm1) mMode = 0;
      else if (cmr) mMode = 1;
      else if (cma) mMode = 2;
    end

    e.xpt = mXpt; e.itable = mItable; e.mode = mMode;
    e.fHl = mHl; e.fA = mA; e.fJp = mJp;
    e.overflow = mOvf; e.conflict = mConflict;
    // The inputs just driven stay stable through the sampling point.
    e.decEn = mValid && !st && !rst;
    sbQueue.push_back(e);
  endtask

  task automatic freeRun(input int n, input logic [7:0] data);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, data, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic endOfInstruction();
    applyStimulus(0, 0, 8'hEE, 1, 1, 1, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compare the DUT with the next expected record after every edge.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      cycleNum++;
      if (sbQueue.size() > 0) begin
        e = sbQueue.pop_front();
        checkOutput("XPT",            {4'h0, XPT},       8'(e.xpt));
        checkOutput("notXPT",         {4'h0, notXPT},    {4'h0, ~4'(e.xpt)});
        checkOutput("ITABLE",         ITABLE,            8'(e.itable));
        checkOutput("notITABLE",      notITABLE,         ~8'(e.itable));
        checkOutput("mode",           {5'h0, CMA, CMR, CM1}, 8'(1 << e.mode));
        checkOutput("flags",          {5'h0, F_JP, F_A, F_HL}, {5'h0, e.fJp, e.fA, e.fHl});
        checkOutput("phase_overflow", {7'h0, phase_overflow}, {7'h0, e.overflow});
        checkOutput("mode_conflict",  {7'h0, mode_conflict},  {7'h0, e.conflict});
        checkOutput("decode_enable",  {7'h0, decode_enable},  {7'h0, e.decEn});
      end
    end
  end

  initial begin
    int waitCycles;
    reset = 1; stall = 0; DataIn = 0;
    PR_Reset_XPT = 0; P2_Reset_ITABLE = 0;
    P2_Set_CM1 = 0; P2_Set_CMR = 0; P2_Set_CMA = 0;
    P2_Set_ILDlnnlHL_1 = 0; P2_Set_ILDAlnnl_1 = 0; P2_Set_IJPnn_1 = 0;

    // Reset, then fetch 0x5A over two free-running cycles.
    applyStimulus(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
    freeRun(2, 8'h5A);

    // Return to XPT=1, stall there for three cycles, then load 0x33.
    endOfInstruction();
    freeRun(1, 8'h99);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 8'h33, 1, 1, 0, 1, 1, 1, 1, 1);
    freeRun(1, 8'h33);

    // Fetch 0x07, run to XPT=6, end the instruction, then refetch 0x11.
    endOfInstruction();
    freeRun(1, 8'h00);
    freeRun(1, 8'h07);
    freeRun(4, 8'h00);
    endOfInstruction();
    freeRun(2, 8'h11);

    // Mode conflict: CMR together with CMA.
    applyStimulus(0, 0, 8'h00, 0, 0, 0, 1, 1, 0, 0, 0);
    freeRun(2, 8'h00);

    // A set strobe beats the ITABLE clear. A lone clear then drops F_JP.
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 1);
    freeRun(1, 8'h00);
    applyStimulus(0, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0);

    // Wrap XPT from 0 through 15 back to 0, run on to 9, then reset mid-way.
    applyStimulus(0, 0, 8'h00, 1, 0, 1, 0, 0, 1, 1, 0);
    freeRun(16, 8'h42);
    freeRun(9, 8'h42);
    applyStimulus(1, 0, 8'h00, 1, 1, 0, 1, 1, 1, 1, 1);

    // Randomised traffic.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 5) == 0,
                    8'($urandom),
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 5) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 11) == 0,
                    $urandom_range(0, 11) == 0);
    end

    // Let the monitor drain the queue, but only for a bounded number of cycles.
    waitCycles = 0;
    while (sbQueue.size() > 0 && waitCycles < 10) begin
      @(posedge clk);
      #2;
      waitCycles++;
    end
    testsRun++;
    if (sbQueue.size() != 0) begin
      failCount++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbQueue.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/norz_phase_sequencer.md
Name: norz_phase_sequencer

Overview:
- Upstream neighbour of the instruction decoder tree (DECODER_I_* family).
- Owns the phase counter XPT, the opcode register ITABLE, the machine-cycle mode register and the multi-byte continuation flags.
- Loads the opcode from the data bus during the M1 fetch phase, presents true and complemented copies to the decoder, and applies the decoder's PR_/P2_ control strobes at the next clock edge.

Parameters:
- FETCH_PHASE, 1, XPT value at which ITABLE is loaded while in M1 mode.
- XPT_W, 4, phase counter width. Fixed at 4; other values are not supported.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  memory wait. Freezes all state and ignores all control strobes.
- DataIn  in  8  opcode/data bus, sampled on fetch.
- PR_Reset_XPT  in  1  decoder strobe: XPT to 0 at next edge.
- P2_Reset_ITABLE  in  1  decoder strobe: clear ITABLE, valid and continuation flags.
- P2_Set_CM1  in  1  next machine cycle is opcode fetch.
- P2_Set_CMR  in  1  next machine cycle is memory read.
- P2_Set_CMA  in  1  next machine cycle is A-access.
- P2_Set_ILDlnnlHL_1  in  1  set continuation flag F_HL.
- P2_Set_ILDAlnnl_1  in  1  set continuation flag F_A.
- P2_Set_IJPnn_1  in  1  set continuation flag F_JP.
- XPT  out  4  phase counter.
- notXPT  out  4  bitwise complement of XPT.
- ITABLE  out  8  opcode register.
- notITABLE  out  8  bitwise complement of ITABLE.
- decode_enable  out  1  enable for the decoder root.
- CM1, CMR, CMA  out  1 each  one-hot mode.
- F_HL, F_A, F_JP  out  1 each  continuation flags.
- phase_overflow  out  1  sticky error: XPT wrapped.
- mode_conflict  out  1  sticky error: more than one P2_Set_CM* strobe in the same cycle.

Behaviour:
- Reset (synchronous, wins over everything):
  - XPT=0, ITABLE=0x00, valid=0.
  - CM1=1, CMR=0, CMA=0.
  - F_HL=F_A=F_JP=0.
  - phase_overflow=0, mode_conflict=0.
- notXPT and notITABLE are purely combinational complements of the registers, valid in the same cycle.
- stall=1: no register changes and all strobes are ignored; decode_enable=0.
- XPT, per edge with stall=0, first match wins:
  1. PR_Reset_XPT: XPT=0.
  2. XPT==15: XPT=0 and phase_overflow=1 (sticky until reset).
  3. Otherwise: XPT=XPT+1.
- Fetch:
  - Condition: CM1=1, XPT==FETCH_PHASE, stall=0, P2_Reset_ITABLE=0.
  - Action: ITABLE<=DataIn, valid<=1.
  - P2_Reset_ITABLE has priority over the load.
- P2_Reset_ITABLE:
  - Sets ITABLE=0x00, valid=0 and clears F_HL, F_A, F_JP.
  - If a P2_Set_*_1 strobe arrives in the same cycle, that flag ends set (set wins over clear for flags).
- Continuation flags: each P2_Set_*_1 sets its flag. Flags hold until P2_Reset_ITABLE or reset.
- Mode register:
  - Any P2_Set_CM* strobe loads the one-hot mode at the next edge.
  - Simultaneous strobes resolve by priority CM1 > CMR > CMA.
  - Simultaneous strobes also set mode_conflict (sticky).
  - With no strobe, the mode holds.
  - The mode is always exactly one-hot.
- decode_enable = valid & ~stall & ~reset.
  - Goes high the cycle after the fetch edge.
  - Goes low the cycle after the P2_Reset_ITABLE edge.
- Strobes with decode_enable=0 (outside stall) are still honoured. This covers the case where the decoder is driven only by a partial enable.
- End-of-instruction is PR_Reset_XPT + P2_Reset_ITABLE + P2_Set_CM1 together. The next cycle has XPT=0, CM1=1, valid=0, and the following fetch occurs at XPT=FETCH_PHASE.
- Reset asserted mid-instruction discards ITABLE and flags. No partial updates from strobes present in that cycle.

Test Plan:
- Reset then 2 free-running cycles with DataIn=0x5A:
  - XPT goes 0→1→2.
  - ITABLE=0x5A after the edge at XPT=1.
  - notITABLE=0xA5.
  - decode_enable=1 at XPT=2.
- Hold stall=1 for 3 cycles at XPT=1 with DataIn=0x33, then release: XPT stays 1 and ITABLE unchanged during the stall; loads 0x33 on the first unstalled edge.
- Pulse PR_Reset_XPT+P2_Reset_ITABLE+P2_Set_CM1 at XPT=6, ITABLE=0x07:
  - Next cycle: XPT=0, ITABLE=0x00, CM1=1, decode_enable=0.
  - Refetch at XPT=1.
- Pulse P2_Set_CMR and P2_Set_CMA together: CM1=1→CMR=1, CMA=0, mode_conflict=1 and stays 1.
- Pulse P2_Set_IJPnn_1 with P2_Reset_ITABLE: F_JP=1, valid=0. A later lone P2_Reset_ITABLE clears F_JP to 0.
- Run 16 edges without PR_Reset_XPT from XPT=0: XPT wraps 15→0, phase_overflow=1. Reset asserted at XPT=9 mid-instruction returns every output to its reset value on the next edge.
